// File: rtl/param_rr_arbiter_mux_if.sv
// Handshake bundle for param_rr_arbiter_mux: N producer streams in, one
// consumer stream out. The packet-lock variant (PARAM_RR_ARBITER_MUX_LOCK_EN)
// adds in_last/out_last.
interface param_rr_arbiter_mux_if #(
   parameter int DATA_WIDTH     = 8,
   parameter int INPUT_CHANNELS = 4
);
   localparam int CHAN_W = $clog2(INPUT_CHANNELS);

   logic [INPUT_CHANNELS*DATA_WIDTH-1:0] in_data;
   logic [INPUT_CHANNELS-1:0]            in_valid;
   logic [INPUT_CHANNELS-1:0]            in_ready;
   logic [DATA_WIDTH-1:0]                out_data;
   logic                                 out_valid;
   logic                                 out_ready;
   logic [CHAN_W-1:0]                    out_chan;
`ifdef PARAM_RR_ARBITER_MUX_LOCK_EN
   logic [INPUT_CHANNELS-1:0]            in_last;
   logic                                 out_last;

   // producers/consumer side
   modport master (output in_data, in_valid, in_last, out_ready,
                   input  in_ready, out_data, out_valid, out_chan, out_last);
   // arbiter side
   modport slave  (input  in_data, in_valid, in_last, out_ready,
                   output in_ready, out_data, out_valid, out_chan, out_last);
`else
   // producers/consumer side
   modport master (output in_data, in_valid, out_ready,
                   input  in_ready, out_data, out_valid, out_chan);
   // arbiter side
   modport slave  (input  in_data, in_valid, out_ready,
                   output in_ready, out_data, out_valid, out_chan);
`endif
endinterface

// File: rtl/param_rr_arbiter_mux.sv
// Round-robin N:1 stream arbiter/mux with a registered output stage.
// Optional packet lock: define PARAM_RR_ARBITER_MUX_LOCK_EN to keep the grant
// on one channel until it delivers a word with in_last set.
module param_rr_arbiter_mux #(
   parameter int DATA_WIDTH     = 8,
   parameter int INPUT_CHANNELS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   param_rr_arbiter_mux_if.slave bus
);
   localparam int                CHAN_W    = $clog2(INPUT_CHANNELS);
   localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(INPUT_CHANNELS - 1);

   logic [INPUT_CHANNELS-1:0][DATA_WIDTH-1:0] words;
   logic [INPUT_CHANNELS-1:0]                 grant;
   logic [DATA_WIDTH-1:0]                     data_q, data_d;
   logic [CHAN_W-1:0]                         chan_q, chan_d;
   logic [CHAN_W-1:0]                         ptr_q, ptr_d;
   logic [CHAN_W-1:0]                         gidx;
   logic                                      valid_q, valid_d;
   logic                                      load, found;
`ifdef PARAM_RR_ARBITER_MUX_LOCK_EN
   logic                                      lock_q, lock_d;
   logic [CHAN_W-1:0]                         lchan_q, lchan_d;
   logic                                      last_q, last_d;
`endif

   assign words = bus.in_data;
   // Output slot is free when empty or being drained this cycle.
   assign load  = ~valid_q | bus.out_ready;

   // Grant: first valid channel after the last winner (or the locked channel).
   always_comb begin : p_grant
      logic [CHAN_W-1:0] idx;
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      idx   = '0;
`ifdef PARAM_RR_ARBITER_MUX_LOCK_EN
      if (lock_q) begin
         found        = bus.in_valid[lchan_q];
         gidx         = lchan_q;
         grant[lchan_q] = bus.in_valid[lchan_q];
      end else begin
`else
      begin
`endif
         for (int k = 0; k < INPUT_CHANNELS; k++) begin
            idx = CHAN_W'((int'(ptr_q) + 1 + k) % INPUT_CHANNELS);
            if (!found && bus.in_valid[idx]) begin
               found      = 1'b1;
               gidx       = idx;
               grant[idx] = 1'b1;
            end
         end
      end
   end

   // Ready is suppressed under backpressure and while reset is asserted.
   assign bus.in_ready = grant & {INPUT_CHANNELS{load & ~rst}};

   // Next state of the output register, pointer and lock.
   always_comb begin
      data_d  = data_q;
      chan_d  = chan_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
`ifdef PARAM_RR_ARBITER_MUX_LOCK_EN
      lock_d  = lock_q;
      lchan_d = lchan_q;
      last_d  = last_q;
`endif
      if (load) begin
         if (found) begin
            data_d  = words[gidx];
            chan_d  = gidx;
            valid_d = 1'b1;
`ifdef PARAM_RR_ARBITER_MUX_LOCK_EN
            last_d  = bus.in_last[gidx];
            // Pointer only moves when a packet ends, so the next packet
            // is arbitrated fairly from the channel that just finished.
            if (bus.in_last[gidx]) begin
               lock_d = 1'b0;
               ptr_d  = gidx;
            end else begin
               lock_d  = 1'b1;
               lchan_d = gidx;
            end
`else
            ptr_d   = gidx;
`endif
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   // State register; pointer resets to the last channel so channel 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         chan_q  <= '0;
         valid_q <= 1'b0;
         ptr_q   <= LAST_CHAN;
`ifdef PARAM_RR_ARBITER_MUX_LOCK_EN
         lock_q  <= 1'b0;
         lchan_q <= '0;
         last_q  <= 1'b0;
`endif
      end else begin
         data_q  <= data_d;
         chan_q  <= chan_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
`ifdef PARAM_RR_ARBITER_MUX_LOCK_EN
         lock_q  <= lock_d;
         lchan_q <= lchan_d;
         last_q  <= last_d;
`endif
      end
   end

   assign bus.out_data  = data_q;
   assign bus.out_chan  = chan_q;
   assign bus.out_valid = valid_q;
`ifdef PARAM_RR_ARBITER_MUX_LOCK_EN
   assign bus.out_last  = last_q;
`endif

endmodule

// File: tb/tb_param_rr_arbiter_mux.sv
// Bench for param_rr_arbiter_mux: directed scenarios with literal expectations
// plus a randomized run against a behavioural model.
module tb_param_rr_arbiter_mux;
   localparam int N  = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   param_rr_arbiter_mux_if #(.DATA_WIDTH(DW), .INPUT_CHANNELS(N)) bus ();

   param_rr_arbiter_mux #(.DATA_WIDTH(DW), .INPUT_CHANNELS(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   bit             model_ok = 0;
   bit             m_valid;
   logic [DW-1:0]  m_data;
   int             m_chan, m_ptr;
   bit             m_lock, m_last;
   int             m_lchan;

   // Winning channel under the current inputs, -1 if none.
   function automatic int pick();
      if (m_lock) return bus.in_valid[m_lchan] ? m_lchan : -1;
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (m_ptr + k) % N;
         if (bus.in_valid[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      int g;
      logic [N-1:0] r;
      r = '0;
      g = pick();
      if (!rst && (!m_valid || bus.out_ready) && g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   always @(posedge clk) begin
      int g;
      bit ld;
      if (rst) begin
         m_valid = 0; m_data = '0; m_chan = 0; m_ptr = N - 1;
         m_lock = 0; m_lchan = 0; m_last = 0; model_ok = 1;
      end else if (model_ok) begin
         ld = !m_valid || bus.out_ready;
         g  = pick();
         if (ld) begin
            if (g >= 0) begin
               m_valid = 1;
               m_data  = bus.in_data[g*DW +: DW];
               m_chan  = g;
`ifdef PARAM_RR_ARBITER_MUX_LOCK_EN
               m_last = bus.in_last[g];
               if (bus.in_last[g]) begin m_lock = 0; m_ptr = g; end
               else begin m_lock = 1; m_lchan = g; end
`else
               m_ptr = g;
`endif
            end else begin
               m_valid = 0;
            end
         end
      end
   end

   // Compare process: every cycle once the model is in a known state.
   always @(negedge clk) begin
      if (model_ok) begin
         chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
         chk("out_data",  32'(bus.out_data),  32'(m_data));
         chk("out_chan",  32'(bus.out_chan),  32'(m_chan));
         chk("in_ready",  32'(bus.in_ready),  32'(exp_ready()));
`ifdef PARAM_RR_ARBITER_MUX_LOCK_EN
         chk("out_last",  32'(bus.out_last),  32'(m_last));
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_words();
      for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = DW'(8'hA0 + i);
   endtask

   task automatic lit_out(input string tag, input int ch);
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".chan"},  32'(bus.out_chan),  32'(ch));
      chk({tag, ".data"},  32'(bus.out_data),  32'(8'hA0 + ch));
   endtask

   initial begin
      set_words();
      bus.in_valid  = '1;
      bus.out_ready = 1'b1;
`ifdef PARAM_RR_ARBITER_MUX_LOCK_EN
      bus.in_last   = '1;
`endif
      rst = 1'b1;

      // reset: two edges with everything valid
      @(negedge clk);
      chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst.out_data",  32'(bus.out_data),  32'd0);
      chk("rst.out_chan",  32'(bus.out_chan),  32'd0);
      chk("rst.in_ready",  32'(bus.in_ready),  32'd0);
      @(negedge clk); #1;
      rst = 1'b0;
      #1 chk("post_rst.in_ready", 32'(bus.in_ready), 32'b0001);

      // round robin with all channels valid
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         lit_out("rr", k % N);
      end

      // sparse: channels 1 and 3, pointer at 1
      #1 bus.in_valid = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         lit_out("sparse", (k % 2 == 0) ? 3 : 1);
         chk("sparse.ready02", 32'(bus.in_ready & 4'b0101), 32'd0);
      end

      // backpressure holding A2
      #1 bus.in_valid = 4'b0100;
      @(negedge clk);
      lit_out("bp_load", 2);
      #1 bus.in_valid = 4'b1111; bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         lit_out("bp_hold", 2);
         chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
      end
      #1 bus.out_ready = 1'b1;
      #1 chk("bp_release.in_ready", 32'(bus.in_ready), 32'b1000);
      @(negedge clk);
      lit_out("bp_next", 3);

      // drain: single word on channel 2 then idle
      #1 bus.in_valid = 4'b0100;
      @(negedge clk);
      lit_out("drain_word", 2);
      #1 bus.in_valid = 4'b0000;
      @(negedge clk);
      chk("drain.valid", 32'(bus.out_valid), 32'd0);
      chk("drain.data",  32'(bus.out_data),  32'hA2);
      chk("drain.chan",  32'(bus.out_chan),  32'd2);
      @(negedge clk);
      chk("idle.valid", 32'(bus.out_valid), 32'd0);
      #1 bus.in_valid = 4'b1001;
      @(negedge clk);
      lit_out("idle_next", 3);
      @(negedge clk);
      lit_out("idle_next2", 0);

`ifdef PARAM_RR_ARBITER_MUX_LOCK_EN
      // packet lock: channel 1 sends 0,0,1 while channel 2 keeps requesting
      #1 rst = 1'b1; bus.in_valid = '0; bus.in_last = '0;
      @(negedge clk); #1;
      rst = 1'b0; bus.in_valid = 4'b0110;
      @(negedge clk);
      lit_out("lock1", 1);
      chk("lock1.last", 32'(bus.out_last), 32'd0);
      #1 bus.in_valid = 4'b0100;
      #1 chk("lock_idle.in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      chk("lock_idle.valid", 32'(bus.out_valid), 32'd0);
      #1 bus.in_valid = 4'b0110;
      @(negedge clk);
      lit_out("lock2", 1);
      chk("lock2.last", 32'(bus.out_last), 32'd0);
      #1 bus.in_last = 4'b0010;
      @(negedge clk);
      lit_out("lock3", 1);
      chk("lock3.last", 32'(bus.out_last), 32'd1);
      #1 bus.in_last = 4'b1111;
      @(negedge clk);
      lit_out("lock_after", 2);
      // reset in the middle of a packet
      #1 bus.in_valid = 4'b0010; bus.in_last = '0;
      @(negedge clk);
      lit_out("lock_mid", 1);
      #1 rst = 1'b1; bus.in_valid = 4'b0101;
      @(negedge clk); #1;
      rst = 1'b0;
      #1 chk("lock_rst.in_ready", 32'(bus.in_ready), 32'b0001);
      @(negedge clk);
      lit_out("lock_rst_next", 0);
`endif

      // randomized traffic, occasional reset
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk); #1;
         bus.in_valid  = N'($urandom);
         bus.in_data   = (N*DW)'({$urandom, $urandom});
         bus.out_ready = ($urandom_range(0, 3) != 0);
         rst           = ($urandom_range(0, 149) == 0);
`ifdef PARAM_RR_ARBITER_MUX_LOCK_EN
         for (int i = 0; i < N; i++) bus.in_last[i] = ($urandom_range(0, 2) == 0);
`endif
      end
      @(negedge clk); #1;
      rst = 1'b0;
      bus.in_valid = '0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/param_rr_arbiter_mux.md
Name: param_rr_arbiter_mux

Overview:
- N-channel, parametrised-width data selector with per-channel valid/ready handshake and round-robin arbitration.
- Output is registered (one pipeline stage).
- Successor to the one-hot combinational selector: replaces the external one-hot select with internal fair arbitration, backpressure and a registered output.
- Sits between multiple producer streams and a single consumer stream.

Parameters:
- DATA_WIDTH, 8, bits per channel word.
- INPUT_CHANNELS, 4, number of input channels (>=2).
- CHAN_W (localparam), $clog2(INPUT_CHANNELS), width of the channel index.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  INPUT_CHANNELS*DATA_WIDTH  channel i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- in_valid  in  INPUT_CHANNELS  per-channel word valid.
- in_ready  out  INPUT_CHANNELS  per-channel accept; combinational.
- out_data  out  DATA_WIDTH  registered selected word.
- out_valid  out  1  registered valid.
- out_ready  in  1  consumer accept.
- out_chan  out  CHAN_W  index of the channel that supplied out_data.

Behaviour:
- Clock and reset: one clock domain, clk; reset rst is synchronous, active-high.
- Reset values: out_valid=0, out_data=0, out_chan=0, last-grant pointer=INPUT_CHANNELS-1, so channel 0 has top priority after reset.
- Load condition:
  - load = ~out_valid | out_ready.
  - The output register accepts a new word only when load=1.
- Grant (combinational):
  - Search in_valid starting at (pointer+1) mod INPUT_CHANNELS, upward with wrap-around.
  - The first asserted channel wins.
  - grant is one-hot or all-zero.
- Ready: in_ready[i] = grant[i] & load. At most one bit of in_ready is high.
- Transfer: a transfer from channel i occurs when in_valid[i] & in_ready[i]. On the next edge:
  - out_data <= channel i word.
  - out_chan <= i.
  - out_valid <= 1.
  - pointer <= i.
- Drain: if load=1 and no channel is valid, out_valid <= 0. out_data and out_chan hold their last values.
- Backpressure: while out_valid=1 and out_ready=0:
  - all in_ready=0;
  - out_data, out_chan and out_valid are held stable;
  - pointer is unchanged.
- Throughput and latency:
  - Simultaneous out_ready=1 and a new grant: the register is replaced in the same cycle, giving full throughput of 1 word/cycle.
  - Latency from input transfer to out_valid is 1 cycle.
- Fairness: with all channels continuously valid and out_ready=1, grants rotate 0,1,2,...,N-1,0. Each channel waits at most N-1 transfers.
- Pointer update: the pointer advances only on a transfer, never on idle cycles.
- Reset mid-operation: rst overrides everything on that edge. A word held in the output register is discarded, and in_ready is 0 during rst.
- Input stability: no requirement on input stability. A producer may deassert in_valid before it is granted.

Optional Feature:
- Macro: PARAM_RR_ARBITER_MUX_LOCK_EN (packet lock).
- When defined:
  - Adds ports in_last (in, INPUT_CHANNELS) and out_last (out, 1, registered, reset 0).
  - After a transfer with in_last[i]=0, the grant is locked to channel i. Other channels are not granted even if i goes idle.
  - The lock releases after the transfer with in_last[i]=1.
  - out_last mirrors the transferred in_last bit.
  - The pointer updates only at lock release.
  - Reset clears the lock.
- When undefined: no in_last/out_last ports; every word is arbitrated independently, as described above.

Test Plan:
- Reset check: assert rst for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0 during reset. On the first cycle after reset, channel 0 is granted.
- Round-robin: N=4, DATA_WIDTH=8, all in_valid=1, channel i word = 8'hA0+i, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 with out_data A0,A1,A2,A3,A0,A1 and out_valid continuously 1.
- Sparse request: only channels 1 and 3 valid, pointer at 1 -> channel 3 granted, then 1, then 3. Channels 0 and 2 never get in_ready.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 with out_data=8'hA2 -> out_data and out_chan stay 8'hA2 and 2, all in_ready=0, and the next grant after release is channel 3.
- Drain and idle: single word on channel 2, then all in_valid=0 -> out_valid is 1 for exactly one cycle with out_ready=1, then 0. The pointer stays at 2, so the next request on channel 0 or 3 follows the order 3 then 0.
- LOCK_EN: channel 1 sends 3 words with in_last=0,0,1 while channel 2 is continuously valid -> out_chan=1,1,1 with out_last=0,0,1, then 2. Applying rst mid-packet makes channel 0 grantable immediately after reset.
